// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-light traffic controller family: colour
// codes, the light-tracker state type, default phase timings and helpers.
package semaforo_pkg;

  localparam logic [2:0] COR_VERDE    = 3'b001;
  localparam logic [2:0] COR_AMARELO  = 3'b010;
  localparam logic [2:0] COR_VERMELHO = 3'b100;

  // Default phase lengths in clock cycles used by the controller and benches.
  localparam logic [7:0] TEMPO_VERDE    = 8'd5;
  localparam logic [7:0] TEMPO_AMARELO  = 8'd3;
  localparam logic [7:0] TEMPO_VERMELHO = 8'd6;

  typedef enum logic [1:0] {
    LUZ_IDLE     = 2'd0,
    LUZ_VERDE    = 2'd1,
    LUZ_AMARELO  = 2'd2,
    LUZ_VERMELHO = 2'd3
  } luz_estado_t;

  // True when the bus carries exactly one of the three legal colour codes.
  function automatic logic eh_valido(input logic [2:0] cor);
    return (cor == COR_VERDE) || (cor == COR_AMARELO) || (cor == COR_VERMELHO);
  endfunction

  // Maps a legal colour code to its tracker state; illegal codes map to IDLE.
  function automatic luz_estado_t cor_para_estado(input logic [2:0] cor);
    luz_estado_t e;
    case (cor)
      COR_VERDE:    e = LUZ_VERDE;
      COR_AMARELO:  e = LUZ_AMARELO;
      COR_VERMELHO: e = LUZ_VERMELHO;
      default:      e = LUZ_IDLE;
    endcase
    return e;
  endfunction

  // The only colour a light may legally move to from the given one.
  function automatic luz_estado_t sucessor(input luz_estado_t e);
    luz_estado_t s;
    case (e)
      LUZ_VERDE:    s = LUZ_AMARELO;
      LUZ_AMARELO:  s = LUZ_VERMELHO;
      LUZ_VERMELHO: s = LUZ_VERDE;
      default:      s = LUZ_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/semaforo_monitor_luz.sv
// Tracker for a single light: follows its colour, times each phase and
// raises one-cycle pulses on sequence or duration violations.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   LUZ_IDLE     | no legal sample tracked yet (after reset/bad code)
//   LUZ_VERDE    | light is green, cont = cycles spent green so far
//   LUZ_AMARELO  | light is yellow, cont = cycles spent yellow so far
//   LUZ_VERMELHO | light is red, cont = cycles spent red so far
//
// Pulses are combinational from the current sample and registered state,
// so the top level can register them on the same edge the sample is taken.
module semaforo_monitor_luz
  import semaforo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cor,
  input  logic [7:0] T_AMARELO,
  input  logic [7:0] T_VERDE_MIN,
  output logic       erro_seq_p,
  output logic       erro_tempo_p,
  output logic       entrou_verde_p
);

  luz_estado_t estado, estado_n, alvo;
  logic [7:0]  cont, cont_n;

  // State and phase-duration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= LUZ_IDLE;
      cont   <= 8'd0;
    end else begin
      estado <= estado_n;
      cont   <= cont_n;
    end
  end

  // Next-state, duration update and violation pulses for the current sample.
  always_comb begin
    estado_n       = estado;
    cont_n         = cont;
    erro_seq_p     = 1'b0;
    erro_tempo_p   = 1'b0;
    entrou_verde_p = 1'b0;
    alvo           = cor_para_estado(cor);

    if (!eh_valido(cor)) begin
      // A corrupt sample drops tracking; the next legal one starts fresh.
      estado_n = LUZ_IDLE;
      cont_n   = 8'd0;
    end else if (estado == LUZ_IDLE) begin
      estado_n = alvo;
      cont_n   = 8'd1;
    end else if (alvo == estado) begin
      if (cont != 8'hFF) begin
        cont_n = cont + 8'd1;
      end
    end else begin
      estado_n = alvo;
      cont_n   = 8'd1;
      if (alvo == sucessor(estado)) begin
        if ((estado == LUZ_AMARELO) && (cont != T_AMARELO)) begin
          erro_tempo_p = 1'b1;
        end
        if ((estado == LUZ_VERDE) && (cont < T_VERDE_MIN)) begin
          erro_tempo_p = 1'b1;
        end
        if (alvo == LUZ_VERDE) begin
          entrou_verde_p = 1'b1;
        end
      end else begin
        // Out-of-order change: the finished phase length is meaningless.
        erro_seq_p = 1'b1;
      end
    end
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive safety watchdog for the two-light controller. Samples both light
// buses every clock, latches sticky error flags, counts completed A cycles
// and pedestrian button presses. Drives nothing back to the controller.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter logic [7:0] T_AMARELO   = 8'd3,
  parameter logic [7:0] T_VERDE_MIN = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       bt,
  output logic       err_conflito,
  output logic       err_codigo,
  output logic       err_seq,
  output logic       err_tempo,
  output logic       ok,
  output logic [7:0] ciclos_a,
  output logic [7:0] pedidos
);

  logic seq_a, tempo_a, verde_a;
  logic seq_b, tempo_b, verde_b;
  logic bt_q;
  logic conflito_n, codigo_n, seq_n, tempo_n;

  semaforo_monitor_luz u_luz_a (
    .clk            (clk),
    .rst            (rst),
    .cor            (A),
    .T_AMARELO      (T_AMARELO),
    .T_VERDE_MIN    (T_VERDE_MIN),
    .erro_seq_p     (seq_a),
    .erro_tempo_p   (tempo_a),
    .entrou_verde_p (verde_a)
  );

  semaforo_monitor_luz u_luz_b (
    .clk            (clk),
    .rst            (rst),
    .cor            (B),
    .T_AMARELO      (T_AMARELO),
    .T_VERDE_MIN    (T_VERDE_MIN),
    .erro_seq_p     (seq_b),
    .erro_tempo_p   (tempo_b),
    .entrou_verde_p (verde_b)
  );

  // Next value of each sticky flag: hold once set, or set on a new event.
  always_comb begin
    codigo_n   = err_codigo | ~eh_valido(A) | ~eh_valido(B);
    conflito_n = err_conflito
               | (eh_valido(A) & eh_valido(B)
                  & (A != COR_VERMELHO) & (B != COR_VERMELHO));
    seq_n      = err_seq | seq_a | seq_b;
    tempo_n    = err_tempo | tempo_a | tempo_b;
  end

  // Sticky flags plus ok, registered together so ok falls with the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_conflito <= 1'b0;
      err_codigo   <= 1'b0;
      err_seq      <= 1'b0;
      err_tempo    <= 1'b0;
      ok           <= 1'b1;
    end else begin
      err_conflito <= conflito_n;
      err_codigo   <= codigo_n;
      err_seq      <= seq_n;
      err_tempo    <= tempo_n;
      ok           <= ~(conflito_n | codigo_n | seq_n | tempo_n);
    end
  end

  // Completed A cycles: each tracked red-to-green entry on light A.
  always_ff @(posedge clk) begin
    if (rst) begin
      ciclos_a <= 8'd0;
    end else if (verde_a) begin
      ciclos_a <= ciclos_a + 8'd1;
    end
  end

  // Button rising-edge counter; bt never influences the checks.
  always_ff @(posedge clk) begin
    if (rst) begin
      pedidos <= 8'd0;
      bt_q    <= 1'b0;
    end else begin
      if (bt && !bt_q) begin
        pedidos <= pedidos + 8'd1;
      end
      bt_q <= bt;
    end
  end

  // Green entries on B are not counted; the pulse only matters for light A.
  logic unused_verde_b;
  assign unused_verde_b = verde_b;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: stimulus drives the lights and pushes
// the reference model's expected outputs; a monitor pops and compares.
module tb_semaforo_monitor;

  localparam int TA = 3;
  localparam int TV = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] A = 3'b100;
  logic [2:0] B = 3'b100;
  logic       bt = 1'b0;
  logic       err_conflito, err_codigo, err_seq, err_tempo, ok;
  logic [7:0] ciclos_a, pedidos;

  semaforo_monitor #(.T_AMARELO(8'(TA)), .T_VERDE_MIN(8'(TV))) dut (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .bt           (bt),
    .err_conflito (err_conflito),
    .err_codigo   (err_codigo),
    .err_seq      (err_seq),
    .err_tempo    (err_tempo),
    .ok           (ok),
    .ciclos_a     (ciclos_a),
    .pedidos      (pedidos)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       conflito;
    logic       codigo;
    logic       seq;
    logic       tempo;
    logic       ok;
    logic [7:0] ciclos;
    logic [7:0] pedidos;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- reference model ----------------
  // Colour as an index 0=green,1=yellow,2=red; -1 means not tracked/invalid.
  int m_col[2];
  int m_len[2];
  bit m_conf, m_cod, m_seq, m_tmp, m_bt_prev;
  int m_ciclos, m_ped;
  bit t_seq, t_tmp, t_verde;

  function automatic int idx_of(logic [2:0] c);
    if (c == 3'b001) return 0;
    if (c == 3'b010) return 1;
    if (c == 3'b100) return 2;
    return -1;
  endfunction

  function automatic void track(int k, logic [2:0] c);
    int i, dur;
    i = idx_of(c);
    t_seq = 0; t_tmp = 0; t_verde = 0;
    if (i < 0) begin
      m_col[k] = -1; m_len[k] = 0;
    end else if (m_col[k] < 0) begin
      m_col[k] = i; m_len[k] = 1;
    end else if (i == m_col[k]) begin
      m_len[k]++;
    end else begin
      dur = (m_len[k] > 255) ? 255 : m_len[k];
      if (i == (m_col[k] + 1) % 3) begin
        if (m_col[k] == 1 && dur != TA) t_tmp = 1;
        if (m_col[k] == 0 && dur < TV) t_tmp = 1;
        if (i == 0) t_verde = 1;
      end else begin
        t_seq = 1;
      end
      m_col[k] = i; m_len[k] = 1;
    end
  endfunction

  function automatic exp_t model_step(logic [2:0] a, logic [2:0] b, logic btv, logic r);
    exp_t e;
    int ia, ib;
    if (r) begin
      m_col[0] = -1; m_col[1] = -1; m_len[0] = 0; m_len[1] = 0;
      m_conf = 0; m_cod = 0; m_seq = 0; m_tmp = 0; m_bt_prev = 0;
      m_ciclos = 0; m_ped = 0;
    end else begin
      ia = idx_of(a); ib = idx_of(b);
      if (ia < 0 || ib < 0) m_cod = 1;
      if (ia >= 0 && ib >= 0 && ia != 2 && ib != 2) m_conf = 1;
      track(0, a);
      if (t_seq) m_seq = 1;
      if (t_tmp) m_tmp = 1;
      if (t_verde) m_ciclos = (m_ciclos + 1) % 256;
      track(1, b);
      if (t_seq) m_seq = 1;
      if (t_tmp) m_tmp = 1;
      if (btv && !m_bt_prev) m_ped = (m_ped + 1) % 256;
      m_bt_prev = btv;
    end
    e.conflito = m_conf;
    e.codigo   = m_cod;
    e.seq      = m_seq;
    e.tempo    = m_tmp;
    e.ok       = !(m_conf || m_cod || m_seq || m_tmp);
    e.ciclos   = 8'(m_ciclos);
    e.pedidos  = 8'(m_ped);
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic btv, input logic r);
    @(negedge clk);
    A = a; B = b; bt = btv; rst = r;
    sb_q.push_back(model_step(a, b, btv, r));
  endtask

  task automatic reset_step();
    step(3'b100, 3'b100, 1'b0, 1'b1);
  endtask

  task automatic repeat_step(input logic [2:0] a, input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b0, 1'b0);
  endtask

  // Three A cycles with B running green/yellow inside A's red window.
  task automatic legal_run(input int y_b);
    reset_step();
    for (int rep = 0; rep < 3; rep++) begin
      repeat_step(3'b001, 3'b100, 1);
      repeat_step(3'b010, 3'b100, 3);
      repeat_step(3'b100, 3'b001, 1);
      repeat_step(3'b100, 3'b010, y_b);
    end
    repeat_step(3'b100, 3'b100, 1);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("err_conflito", int'(err_conflito), int'(e.conflito));
      chk("err_codigo",   int'(err_codigo),   int'(e.codigo));
      chk("err_seq",      int'(err_seq),      int'(e.seq));
      chk("err_tempo",    int'(err_tempo),    int'(e.tempo));
      chk("ok",           int'(ok),           int'(e.ok));
      chk("ciclos_a",     int'(ciclos_a),     int'(e.ciclos));
      chk("pedidos",      int'(pedidos),      int'(e.pedidos));
    end
  end

  // ---------------- main sequence ----------------
  int g_col[2];

  function automatic logic [2:0] gen_light(int k);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) begin
    end else if (r < 90) begin
      g_col[k] = (g_col[k] + 1) % 3;
    end else if (r < 96) begin
      g_col[k] = int'($urandom_range(0, 2));
    end else begin
      return 3'($urandom);
    end
    return 3'b001 << g_col[k];
  endfunction

  initial begin
    int wait_cnt;
    int next_rst;
    logic [2:0] ga, gb;

    // legal run with one-cycle B yellow (timing error), then three-cycle yellow
    legal_run(1);
    legal_run(3);

    // conflict for one cycle, then legal inputs again
    reset_step();
    repeat_step(3'b100, 3'b100, 2);
    repeat_step(3'b001, 3'b010, 1);
    repeat_step(3'b100, 3'b100, 3);

    // bad code followed by green: tracking restarts, no sequence error
    reset_step();
    repeat_step(3'b100, 3'b100, 2);
    repeat_step(3'b011, 3'b100, 1);
    repeat_step(3'b001, 3'b100, 3);

    // green straight to red
    reset_step();
    repeat_step(3'b001, 3'b100, 2);
    repeat_step(3'b100, 3'b100, 2);

    // short yellow, then exact yellow
    reset_step();
    repeat_step(3'b010, 3'b100, 1);
    repeat_step(3'b100, 3'b100, 1);
    repeat_step(3'b001, 3'b100, 1);
    repeat_step(3'b010, 3'b100, 2);
    repeat_step(3'b100, 3'b100, 2);
    reset_step();
    repeat_step(3'b001, 3'b100, 1);
    repeat_step(3'b010, 3'b100, 3);
    repeat_step(3'b100, 3'b100, 2);
    repeat_step(3'b001, 3'b100, 1);

    // yellow held past saturation, leaving compared as 255
    reset_step();
    repeat_step(3'b001, 3'b100, 1);
    repeat_step(3'b010, 3'b100, 300);
    repeat_step(3'b100, 3'b100, 2);

    // button pulses and a held press, then reset after a forced error
    reset_step();
    for (int i = 0; i < 20; i++)
      step(3'b100, 3'b100, (i == 4 || i == 8 || (i >= 12 && i < 17)), 1'b0);
    repeat_step(3'b001, 3'b001, 1);
    repeat_step(3'b100, 3'b100, 1);
    reset_step();
    repeat_step(3'b100, 3'b100, 2);

    // randomized traffic with periodic resets
    g_col[0] = 2; g_col[1] = 2;
    reset_step();
    next_rst = int'($urandom_range(20, 60));
    for (int n = 0; n < 3000; n++) begin
      if (n == next_rst) begin
        step(3'b100, 3'b100, 1'($urandom), 1'b1);
        next_rst = n + int'($urandom_range(20, 60));
      end else begin
        ga = gen_light(0);
        gb = gen_light(1);
        step(ga, gb, 1'($urandom_range(0, 3) == 0), 1'b0);
      end
    end

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
